cylon_checker: RTL and testbench

//  Receive-side monitor for an 8-bit one-eye cylon LED sweep (0->7->0, period 14 steps).

---
 rtl/cylon_pkg.sv | 29 ++
 rtl/cylon_onehot_decode.sv | 23 ++
 rtl/cylon_checker.sv | 189 ++++++++++++++++++
 tb/tb_cylon_checker.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cylon_pkg.sv
// rtl/cylon_pkg.sv - shared types, widths and step helpers for the cylon checker
// Contents: state_t {UNLOCKED, ACQUIRE, LOCKED}; PAT_W, POS_W, CNT_W widths;
//   next_pos() expected bounce step; land_dir() direction after landing.
package cylon_pkg;

  localparam int PAT_W = 8;
  localparam int POS_W = 3;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  // Next eye position of a legal sweep, bouncing off both ends.
  function automatic logic [POS_W-1:0] next_pos(input logic [POS_W-1:0] pos, input logic up);
    if (up) return (pos == '1) ? pos - 3'd1 : pos + 3'd1;
    return (pos == '0) ? pos + 3'd1 : pos - 3'd1;
  endfunction

  // Direction after arriving at new_pos; at the ends only one way out exists.
  function automatic logic land_dir(input logic [POS_W-1:0] new_pos, input logic up);
    if (new_pos == '1) return 1'b0;
    if (new_pos == '0) return 1'b1;
    return up;
  endfunction

endpackage

// File: rtl/cylon_onehot_decode.sv
// rtl/cylon_onehot_decode.sv - combinational one-hot pattern decoder
// Ports: pattern[7:0] in; valid out (exactly one bit set); pos[2:0] out (bit index,
//   0 when not valid).
module cylon_onehot_decode
  import cylon_pkg::*;
(
  input  logic [PAT_W-1:0] pattern,
  output logic             valid,
  output logic [POS_W-1:0] pos
);

  always_comb begin
    // Non-zero with no second bit: clearing the lowest set bit leaves nothing.
    valid = (pattern != '0) && ((pattern & (pattern - 8'd1)) == '0);
    pos   = '0;
    if (valid) begin
      for (int i = 0; i < PAT_W; i++) begin
        if (pattern[i]) pos = POS_W'(i);
      end
    end
  end

endmodule

// File: rtl/cylon_checker.sv
// rtl/cylon_checker.sv - receive-side monitor for a one-eye cylon LED sweep
// Ports: clock; reset (synchronous, active-high); pattern[7:0] sampled every clock;
//   err_clear (strobe, clears err_count and timeout); locked; position[2:0];
//   direction (1 = up); sweep_count[15:0] (wraps); err_count[15:0] (saturates);
//   err_pulse; timeout (sticky stall flag).
// Macro CYLON_CHECK_TIMEOUT_EN enables the stall watchdog (width TIMEOUT_W);
//   without it timeout is tied 0.
module cylon_checker
  import cylon_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int MISS_LIMIT = 3
`ifdef CYLON_CHECK_TIMEOUT_EN
  ,
  parameter int TIMEOUT_W = 24
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [PAT_W-1:0] pattern,
  input  logic             err_clear,
  output logic             locked,
  output logic [POS_W-1:0] position,
  output logic             direction,
  output logic [CNT_W-1:0] sweep_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err_pulse,
  output logic             timeout
);

  logic [PAT_W-1:0] pat_q;
  logic             evt_q, clr_q;
  state_t           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d, exp_pos, dec_pos;
  logic             dir_q, dir_d, dec_valid;
  logic [3:0]       acq_q, acq_d, bad_q, bad_d;
  logic [CNT_W-1:0] sweep_q, sweep_d, err_q, err_d;
  logic             pulse_q, err_hit, adj_up, adj_dn, good;
`ifdef CYLON_CHECK_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 to_q, to_d, stall_hit;
`endif

  cylon_onehot_decode u_decode (
    .pattern (pat_q),
    .valid   (dec_valid),
    .pos     (dec_pos)
  );

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    acq_d   = acq_q;
    bad_d   = bad_q;
    sweep_d = sweep_q;
    err_hit = 1'b0;
`ifdef CYLON_CHECK_TIMEOUT_EN
    stall_hit = 1'b0;
`endif
    exp_pos = next_pos(pos_q, dir_q);
    // End guards keep the 3-bit add/subtract from wrapping into a false neighbour.
    adj_up  = dec_valid && (pos_q != '1) && (dec_pos == pos_q + 3'd1);
    adj_dn  = dec_valid && (pos_q != '0) && (dec_pos == pos_q - 3'd1);
    good    = dec_valid && (dec_pos == exp_pos);

    case (state_q)
      UNLOCKED: begin
        if (evt_q && dec_valid) begin
          state_d = ACQUIRE;
          pos_d   = dec_pos;
          acq_d   = '0;
        end
      end
      ACQUIRE: begin
        if (evt_q) begin
          if (adj_up || adj_dn) begin
            pos_d = dec_pos;
            dir_d = land_dir(dec_pos, adj_up);
            if (acq_q == 4'(LOCK_COUNT - 1)) begin
              state_d = LOCKED;
              acq_d   = '0;
              bad_d   = '0;
            end else begin
              acq_d = acq_q + 4'd1;
            end
          end else begin
            if (dec_valid) pos_d = dec_pos;
            acq_d = '0;
          end
        end
      end
      LOCKED: begin
        if (evt_q) begin
          if (good) begin
            pos_d = dec_pos;
            dir_d = land_dir(dec_pos, adj_up);
            bad_d = '0;
            if (pos_q == 3'd1 && dec_pos == 3'd0) sweep_d = sweep_q + 16'd1;
          end else begin
            err_hit = 1'b1;
            // A legal but unexpected pattern resyncs the eye; junk leaves it alone.
            if (dec_valid) begin
              pos_d = dec_pos;
              if (adj_up || adj_dn) dir_d = land_dir(dec_pos, adj_up);
            end
            if (bad_q == 4'(MISS_LIMIT - 1)) begin
              state_d = UNLOCKED;
              bad_d   = '0;
              acq_d   = '0;
            end else begin
              bad_d = bad_q + 4'd1;
            end
          end
        end
`ifdef CYLON_CHECK_TIMEOUT_EN
        else if (wd_q == '1) begin
          stall_hit = 1'b1;
          err_hit   = 1'b1;
          state_d   = UNLOCKED;
          bad_d     = '0;
          acq_d     = '0;
        end
`endif
      end
      default: state_d = UNLOCKED;
    endcase

    // A clear arriving with an error leaves exactly that one error counted.
    if (clr_q)                          err_d = err_hit ? 16'd1 : 16'd0;
    else if (err_hit && (err_q != '1))  err_d = err_q + 16'd1;
    else                                err_d = err_q;

`ifdef CYLON_CHECK_TIMEOUT_EN
    wd_d = (state_q == LOCKED && !evt_q && wd_q != '1) ? wd_q + 1'b1 : '0;
    to_d = stall_hit | (to_q & ~clr_q);
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pat_q   <= '0;
      evt_q   <= 1'b0;
      clr_q   <= 1'b0;
      state_q <= UNLOCKED;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      acq_q   <= '0;
      bad_q   <= '0;
      sweep_q <= '0;
      err_q   <= '0;
      pulse_q <= 1'b0;
`ifdef CYLON_CHECK_TIMEOUT_EN
      wd_q    <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      // err_clear rides the same register stage as the pattern so both line up.
      pat_q   <= pattern;
      evt_q   <= (pattern != pat_q);
      clr_q   <= err_clear;
      state_q <= state_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      acq_q   <= acq_d;
      bad_q   <= bad_d;
      sweep_q <= sweep_d;
      err_q   <= err_d;
      pulse_q <= err_hit;
`ifdef CYLON_CHECK_TIMEOUT_EN
      wd_q    <= wd_d;
      to_q    <= to_d;
`endif
    end
  end

  assign locked      = (state_q == LOCKED);
  assign position    = pos_q;
  assign direction   = dir_q;
  assign sweep_count = sweep_q;
  assign err_count   = err_q;
  assign err_pulse   = pulse_q;
`ifdef CYLON_CHECK_TIMEOUT_EN
  assign timeout     = to_q;
`else
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_cylon_checker.sv
// tb/tb_cylon_checker.sv - scoreboard bench for cylon_checker with a behavioural model
module tb_cylon_checker;

  localparam int LOCK_COUNT = 4;
  localparam int MISS_LIMIT = 3;
  localparam int SAT_MISS   = 15;
`ifdef CYLON_CHECK_TIMEOUT_EN
  localparam int TW = 4;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pattern = 8'h00;
  logic       err_clear = 1'b0;
  logic       locked, direction, err_pulse, timeout;
  logic [2:0] position;
  logic [15:0] sweep_count, err_count;

  logic [7:0]  pattern_s = 8'h00;
  logic        locked_s, direction_s, err_pulse_s, timeout_s;
  logic [2:0]  position_s;
  logic [15:0] sweep_s, err_count_s;

  always #5 clock = ~clock;

  cylon_checker #(
    .LOCK_COUNT (LOCK_COUNT),
    .MISS_LIMIT (MISS_LIMIT)
`ifdef CYLON_CHECK_TIMEOUT_EN
    ,
    .TIMEOUT_W  (TW)
`endif
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pattern     (pattern),
    .err_clear   (err_clear),
    .locked      (locked),
    .position    (position),
    .direction   (direction),
    .sweep_count (sweep_count),
    .err_count   (err_count),
    .err_pulse   (err_pulse),
    .timeout     (timeout)
  );

  cylon_checker #(
    .LOCK_COUNT (LOCK_COUNT),
    .MISS_LIMIT (SAT_MISS)
  ) dut_sat (
    .clock       (clock),
    .reset       (reset),
    .pattern     (pattern_s),
    .err_clear   (1'b0),
    .locked      (locked_s),
    .position    (position_s),
    .direction   (direction_s),
    .sweep_count (sweep_s),
    .err_count   (err_count_s),
    .err_pulse   (err_pulse_s),
    .timeout     (timeout_s)
  );

  typedef struct packed {
    logic        locked;
    logic [2:0]  pos;
    logic        dir;
    logic [15:0] sweep;
    logic [15:0] err;
    logic        pulse;
    logic        to;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_e, mon_a, m_obs;
  bit   mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Reference model state: mode 0 unlocked, 1 acquiring, 2 locked.
  int         m_mode, m_pos, m_acq, m_bad, m_sweep, m_err, m_wd;
  bit         m_dir, m_to;
  logic [7:0] m_prev;
  int         cy;

  function automatic bit land_up(int np, bit up);
    if (np == 7) return 1'b0;
    if (np == 0) return 1'b1;
    return up;
  endfunction

  function automatic logic [7:0] cy_pat(int ph);
    int p;
    p = (ph < 8) ? ph : 14 - ph;
    return 8'(1 << p);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_acq = 0; m_bad = 0; m_sweep = 0; m_err = 0; m_wd = 0;
    m_dir = 1'b0; m_to = 1'b0; m_prev = 8'h00;
  endtask

  task automatic model_step(input logic [7:0] p, input logic clr);
    bit ev, legal, hit, stall;
    int np, want, pre;
    ev = (p != m_prev);
    m_prev = p;
    legal = ($countones(p) == 1);
    np = 0;
    for (int i = 0; i < 8; i++) if (p[i]) np = i;
    hit = 1'b0; stall = 1'b0; pre = m_mode;
    if (ev) begin
      case (m_mode)
        0: if (legal) begin m_mode = 1; m_pos = np; m_acq = 0; end
        1: begin
          if (legal && (np - m_pos == 1 || m_pos - np == 1)) begin
            m_dir = land_up(np, np > m_pos);
            m_pos = np;
            m_acq++;
            if (m_acq == LOCK_COUNT) begin m_mode = 2; m_acq = 0; m_bad = 0; end
          end else begin
            if (legal) m_pos = np;
            m_acq = 0;
          end
        end
        default: begin
          want = m_dir ? ((m_pos == 7) ? 6 : m_pos + 1) : ((m_pos == 0) ? 1 : m_pos - 1);
          if (legal && np == want) begin
            if (m_pos == 1 && np == 0) m_sweep = (m_sweep + 1) % 65536;
            m_dir = land_up(np, np > m_pos);
            m_pos = np;
            m_bad = 0;
          end else begin
            hit = 1'b1;
            if (legal) begin
              if (np - m_pos == 1 || m_pos - np == 1) m_dir = land_up(np, np > m_pos);
              m_pos = np;
            end
            m_bad++;
            if (m_bad == MISS_LIMIT) begin m_mode = 0; m_bad = 0; m_acq = 0; end
          end
        end
      endcase
    end
`ifdef CYLON_CHECK_TIMEOUT_EN
    if (pre == 2 && !ev) begin
      if (m_wd == (1 << TW) - 1) begin
        stall = 1'b1; hit = 1'b1; m_mode = 0; m_bad = 0; m_acq = 0; m_wd = 0;
      end else begin
        m_wd++;
      end
    end else begin
      m_wd = 0;
    end
`endif
    if (clr) m_err = hit ? 1 : 0;
    else if (hit && m_err < 65535) m_err++;
    m_to = stall | (m_to & !clr);
    m_obs = {(m_mode == 2), 3'(m_pos), m_dir, 16'(m_sweep), 16'(m_err), hit, m_to};
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic cyc(input logic [7:0] p, input logic clr);
    @(negedge clock);
    pattern = p;
    err_clear = clr;
    model_step(p, clr);
    exp_q.push_back(m_obs);
  endtask

  task automatic cy_step(input int hold, input logic clr);
    cy = (cy + 1) % 14;
    cyc(cy_pat(cy), clr);
    for (int h = 1; h < hold; h++) cyc(cy_pat(cy), 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; mon_en = 1'b0; pattern = 8'h00; err_clear = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clock);
    check("rst_locked", 32'(locked), 0);
    check("rst_position", 32'(position), 0);
    check("rst_direction", 32'(direction), 0);
    check("rst_sweep", 32'(sweep_count), 0);
    check("rst_err", 32'(err_count), 0);
    check("rst_pulse", 32'(err_pulse), 0);
    check("rst_timeout", 32'(timeout), 0);
    reset = 1'b0;
    model_reset();
    model_step(8'h00, 1'b0);
    exp_q.push_back(m_obs);
    mon_en = 1'b1;
  endtask

  always @(posedge clock) begin
    #1;
    if (mon_en && exp_q.size() >= 2) begin
      mon_e = exp_q.pop_front();
      mon_a = {locked, position, direction, sweep_count, err_count, err_pulse, timeout};
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL scoreboard t=%0t got l=%0b p=%0d d=%0b sw=%0d e=%0d pu=%0b to=%0b want l=%0b p=%0d d=%0b sw=%0d e=%0d pu=%0b to=%0b",
                 $time, mon_a.locked, mon_a.pos, mon_a.dir, mon_a.sweep, mon_a.err, mon_a.pulse, mon_a.to,
                 mon_e.locked, mon_e.pos, mon_e.dir, mon_e.sweep, mon_e.err, mon_e.pulse, mon_e.to);
      end
    end
  end

  initial begin
    int r, ph;
    logic clr;
    model_reset();
    do_reset();

    // Clean acquisition with 3 clocks per step, then two round trips.
    cy = 0;
    repeat (3) cyc(cy_pat(0), 1'b0);
    repeat (20) cy_step(3, 1'b0);
    repeat (28) cy_step(1, 1'b0);

    // Multi-hot glitch at pos 3 moving up, then resume at pos 4.
    while (cy != 3) cy_step(1, 1'b0);
    cyc(8'h24, 1'b0);
    cyc(8'h24, 1'b0);
    cy_step(2, 1'b0);
    repeat (10) cy_step(1, 1'b0);

    // Three consecutive jumps drop lock; a clean run relocks.
    while (cy != 0) cy_step(1, 1'b0);
    cyc(8'h10, 1'b0);
    cyc(8'h80, 1'b0);
    cyc(8'h02, 1'b0);
    cy = 1;
    repeat (12) cy_step(2, 1'b0);

    // Clear coincident with an error, then a plain clear.
    cyc(8'hFF, 1'b1);
    cy_step(1, 1'b0);
    cyc(cy_pat(cy), 1'b1);
    repeat (4) cy_step(1, 1'b0);

    // Randomized mix of good steps, legal jumps, junk and clears; one mid-run reset.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        do_reset();
        cy = 0;
        cyc(cy_pat(0), 1'b0);
      end
      r = $urandom_range(0, 15);
      clr = ($urandom_range(0, 19) == 0);
      if (r < 10)      cy_step($urandom_range(1, 3), clr);
      else if (r < 12) cyc(8'(1 << $urandom_range(0, 7)), clr);
      else if (r < 14) cyc(8'($urandom), clr);
      else             cyc(pattern, clr);
    end

    // Stalled pattern while locked.
    do_reset();
    cy = 0;
    cyc(cy_pat(0), 1'b0);
    repeat (10) cy_step(1, 1'b0);
    repeat (24) cyc(cy_pat(cy), 1'b0);
`ifdef CYLON_CHECK_TIMEOUT_EN
    check("stall_timeout", 32'(timeout), 1);
    check("stall_locked", 32'(locked), 0);
`else
    check("stall_timeout", 32'(timeout), 0);
    check("stall_locked", 32'(locked), 1);
`endif
    repeat (3) cyc(pattern, 1'b0);
    mon_en = 1'b0;

    // Saturation on a second instance: 14 junk events then one good step, repeated.
    ph = 0;
    for (int s = 0; s < 6; s++) begin
      @(negedge clock); pattern_s = cy_pat(ph);
      if (s < 5) ph++;
    end
    for (int blk = 0; blk < 4682; blk++) begin
      for (int k = 0; k < 14; k++) begin
        @(negedge clock); pattern_s = (k % 2 == 0) ? 8'hFF : 8'h00;
      end
      ph = (ph + 1) % 14;
      @(negedge clock); pattern_s = cy_pat(ph);
      if (blk == 0) begin
        repeat (2) @(negedge clock);
        check("sat_err_early", 32'(err_count_s), 14);
        check("sat_locked_early", 32'(locked_s), 1);
      end
    end
    repeat (3) @(negedge clock);
    check("sat_err_final", 32'(err_count_s), 32'hFFFF);
    check("sat_locked_final", 32'(locked_s), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
